triangle_fifo: RTL and testbench

//  Buffers screen-space triangles between the projection stage (writer) and the
//  per-frame triangle drawer (reader). Stores packed triangles of 3 vertices x
//  (x,y) x CW bits. Read data is registered: it is valid the cycle after a read.

---
 rtl/triangle_fifo.sv | 91 +++++++++
 tb/tb_triangle_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/triangle_fifo.sv
// Triangle FIFO between the projection stage and the per-frame triangle drawer.
// Registered read data, frame-start flush, backpressure and sticky error flags.
module triangle_fifo #(
   parameter int unsigned CW     = 10,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned AW     = 6,
   parameter int unsigned AF_GAP = 4
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      flush,
   input  logic                      fifo_w,
   input  logic [2:0][1:0][CW-1:0]   tri_in,
   output logic                      fifo_full,
   output logic                      almost_full,
   input  logic                      fifo_r,
   output logic [2:0][1:0][CW-1:0]   triangle_data,
   output logic                      fifo_empty,
   output logic [AW:0]               count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned CNTW = AW + 1;

   logic [2:0][1:0][CW-1:0] mem [DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [CNTW-1:0]         count_next;
   logic                    wr_acc;
   logic                    rd_acc;

   // Flags decode straight from the registered occupancy.
   assign fifo_full   = (count == CNTW'(DEPTH));
   assign fifo_empty  = (count == CNTW'(0));
   assign almost_full = (count >= CNTW'(DEPTH - AF_GAP));

   // Flush discards both strobes; acceptance uses this cycle's flags (no fall-through).
   assign wr_acc = fifo_w && !fifo_full  && !flush;
   assign rd_acc = fifo_r && !fifo_empty && !flush;

   always_comb begin
      count_next = count;
      if (wr_acc && !rd_acc) begin
         count_next = count + CNTW'(1);
      end else if (!wr_acc && rd_acc) begin
         count_next = count - CNTW'(1);
      end
   end

   // Storage array has no reset path so it maps onto a dual-port RAM.
   always_ff @(posedge Clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= tri_in;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         triangle_data <= '0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else if (flush) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         triangle_data <= '0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         count <= count_next;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr        <= rd_ptr + AW'(1);
            triangle_data <= mem[rd_ptr];
         end
         if (fifo_w && fifo_full) begin
            overflow <= 1'b1;
         end
         if (fifo_r && fifo_empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_triangle_fifo.sv
// Scoreboard bench for triangle_fifo: expected triangles queued on accepted
// writes and compared against triangle_data after accepted reads.
module tb_triangle_fifo;

   localparam int unsigned CW    = 10;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   typedef logic [2:0][1:0][CW-1:0] tri_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        flush = 1'b0;
   logic        fifo_w = 1'b0;
   logic        fifo_r = 1'b0;
   tri_t        tri_in = '0;
   tri_t        triangle_data;
   logic        fifo_full, almost_full, fifo_empty, overflow, underflow;
   logic [AW:0] count;

   int n_checks = 0;
   int n_pass   = 0;

   // reference state
   tri_t sb_q[$];
   tri_t exp_data = '0;
   bit   exp_ovf  = 1'b0;
   bit   exp_udf  = 1'b0;

   triangle_fifo #(.CW(CW), .DEPTH(DEPTH), .AW(AW), .AF_GAP(4)) dut (
      .Clk(Clk), .Reset(Reset), .flush(flush), .fifo_w(fifo_w), .tri_in(tri_in),
      .fifo_full(fifo_full), .almost_full(almost_full), .fifo_r(fifo_r),
      .triangle_data(triangle_data), .fifo_empty(fifo_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      int n;
      n = sb_q.size();
      check({tag, ":count"}, 64'(count), 64'(n));
      check({tag, ":empty"}, 64'(fifo_empty), 64'(n == 0));
      check({tag, ":full"},  64'(fifo_full), 64'(n == DEPTH));
      check({tag, ":afull"}, 64'(almost_full), 64'(n >= DEPTH - 4));
      check({tag, ":ovf"},   64'(overflow), 64'(exp_ovf));
      check({tag, ":udf"},   64'(underflow), 64'(exp_udf));
      check({tag, ":data"},  64'(triangle_data), 64'(exp_data));
   endtask

   function automatic void model_clear();
      sb_q.delete();
      exp_data = '0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
   endfunction

   // One clock: drive strobes, advance the model, compare after the edge.
   task automatic step(input string tag, input bit w, input bit r, input tri_t d, input bit fl);
      bit full, empty;
      fifo_w = w; fifo_r = r; tri_in = d; flush = fl;
      @(posedge Clk);
      #1;
      if (fl) begin
         model_clear();
      end else begin
         full  = (sb_q.size() == DEPTH);
         empty = (sb_q.size() == 0);
         if (w && full)  exp_ovf = 1'b1;
         if (r && empty) exp_udf = 1'b1;
         if (r && !empty) exp_data = sb_q.pop_front();
         if (w && !full)  sb_q.push_back(d);
      end
      check_all(tag);
   endtask

   function automatic tri_t rnd_tri();
      tri_t t;
      for (int v = 0; v < 3; v++)
         for (int c = 0; c < 2; c++)
            t[v][c] = CW'($urandom_range(0, (1 << CW) - 1));
      return t;
   endfunction

   tri_t ta, tb, tc;
   tri_t last_data;

   initial begin
      ta = rnd_tri(); tb = rnd_tri(); tc = rnd_tri();

      // reset state
      repeat (2) @(posedge Clk);
      #1;
      model_clear();
      check_all("reset");
      @(negedge Clk);
      Reset = 1'b0;

      // 1: three writes then one read
      step("t1_wa", 1, 0, ta, 0);
      step("t1_wb", 1, 0, tb, 0);
      step("t1_wc", 1, 0, tc, 0);
      step("t1_rd", 0, 1, '0, 0);
      check("t1_first_is_a", 64'(triangle_data), 64'(ta));
      step("t1_idle", 0, 0, '0, 0);
      step("t1_drain1", 0, 1, '0, 0);
      step("t1_drain2", 0, 1, '0, 0);

      // 2: fill, overflow, full drain in order
      for (int i = 0; i < DEPTH; i++) step("t2_fill", 1, 0, rnd_tri(), 0);
      step("t2_ovf", 1, 0, rnd_tri(), 0);
      step("t2_ovf_rw", 1, 1, rnd_tri(), 0);
      for (int i = 0; i < DEPTH + 1; i++) step("t2_drain", 0, 1, '0, 0);

      // 3: reads on empty hold data and set underflow
      last_data = exp_data;
      for (int i = 0; i < 3; i++) step("t3_udf", 0, 1, '0, 0);
      check("t3_data_held", 64'(triangle_data), 64'(last_data));

      // 4: simultaneous read/write at count 1 across pointer wrap
      step("t4_seed", 1, 0, rnd_tri(), 0);
      for (int i = 0; i < 200; i++) step("t4_rw", 1, 1, rnd_tri(), 0);

      // 5: flush at count 10 beats both strobes
      for (int i = 0; i < 9; i++) step("t5_fill", 1, 0, rnd_tri(), 0);
      check("t5_count10", 64'(count), 64'(10));
      step("t5_flush", 1, 1, rnd_tri(), 1);
      step("t5_after", 0, 0, '0, 0);

      // 6: async reset between edges during a burst
      for (int i = 0; i < 5; i++) step("t6_burst", 1, 0, rnd_tri(), 0);
      step("t6_rd", 1, 1, rnd_tri(), 0);
      #3;
      Reset = 1'b1;
      #1;
      model_clear();
      check_all("t6_async");
      @(negedge Clk);
      Reset = 1'b0;
      step("t6_post", 1, 0, ta, 0);
      step("t6_post_rd", 0, 1, '0, 0);

      fifo_w = 1'b0; fifo_r = 1'b0; flush = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
